// File: rtl/knn_local_sp_arbiter.sv
// knn_local_sp_arbiter
// Shares the single address0/ce0/we0 port of one URAM partition buffer between
// a write requester (point loader) and a read requester (distance compute).
// Reads return in issue order through a credit-limited first-word-fall-through
// response FIFO, so the compute side can stall without losing data.
// Optional build macro: KNN_SP_ARB_STATS_EN adds the stat_conflict and
// stat_rd_nocredit saturating counter outputs.

module knn_local_sp_arbiter #(
  parameter int DataWidth    = 256,
  parameter int AddressWidth = 11,
  parameter int RD_LAT       = 2,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AddressWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0]    wr_data,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [AddressWidth-1:0] rd_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_data,
  output logic [AddressWidth-1:0] mem_address0,
  output logic                    mem_ce0,
  output logic                    mem_we0,
  output logic [DataWidth-1:0]    mem_d0,
  input  logic [DataWidth-1:0]    mem_q0
`ifdef KNN_SP_ARB_STATS_EN
  ,
  output logic [31:0]             stat_conflict,
  output logic [31:0]             stat_rd_nocredit
`endif
);

  // Credit counter covers 0..RSP_DEPTH; FIFO pointers index RSP_DEPTH slots.
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] MAX_OUT   = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(RSP_DEPTH - 1);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_WR,
    GRANT_RD
  } grant_t;

  grant_t                grant;
  logic                  wr_elig;
  logic                  rd_elig;
  logic                  contested;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  last_wr;

  logic [CW-1:0]         outstanding;
  logic [RD_LAT-1:0]     rd_pipe;

  logic [DataWidth-1:0]  fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  // Eligibility and round-robin grant; nothing is granted while reset is held.
  always_comb begin
    wr_elig   = !reset && wr_valid;
    rd_elig   = !reset && rd_valid && (outstanding < MAX_OUT);
    contested = wr_elig && rd_elig;
    grant     = GRANT_NONE;
    if (contested) begin
      grant = last_wr ? GRANT_RD : GRANT_WR;
    end else if (wr_elig) begin
      grant = GRANT_WR;
    end else if (rd_elig) begin
      grant = GRANT_RD;
    end
    grant_wr = (grant == GRANT_WR);
    grant_rd = (grant == GRANT_RD);
  end

  // Handshake and memory port drive follow the grant in the same cycle.
  always_comb begin
    wr_ready     = grant_wr;
    rd_ready     = grant_rd;
    mem_ce0      = grant_wr || grant_rd;
    mem_we0      = grant_wr;
    mem_address0 = grant_wr ? wr_addr : rd_addr;
    mem_d0       = wr_data;
  end

  // Round-robin history only moves when both sides actually competed.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr <= 1'b1;
    end else if (contested) begin
      last_wr <= grant_wr;
    end
  end

  // Valid shift register: the tail bit marks the cycle mem_q0 holds read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= grant_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  // FIFO status and response channel.
  always_comb begin
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == MAX_OUT);
    push       = rd_pipe[RD_LAT-1];
    pop        = !fifo_empty && rsp_ready;
    rsp_valid  = !fifo_empty;
    rsp_data   = fifo_mem[rd_ptr];
  end

  // Credits: a read grant takes one, a response pop returns one.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({grant_rd, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FIFO pointers and occupancy; reset discards any buffered responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage is data-only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_q0;
    end
  end

  // The credit scheme makes a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && fifo_full));
    end
  end

`ifdef KNN_SP_ARB_STATS_EN
  logic rd_nocredit;

  // Cycles where a read is blocked purely by lack of credit.
  always_comb begin
    rd_nocredit = rd_valid && (outstanding == MAX_OUT);
  end

  // Saturating contention and credit-starvation counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_conflict    <= '0;
      stat_rd_nocredit <= '0;
    end else begin
      if (contested && (stat_conflict != 32'hFFFF_FFFF)) begin
        stat_conflict <= stat_conflict + 32'd1;
      end
      if (rd_nocredit && (stat_rd_nocredit != 32'hFFFF_FFFF)) begin
        stat_rd_nocredit <= stat_rd_nocredit + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_knn_local_sp_arbiter.sv
// Testbench for knn_local_sp_arbiter: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level reference model
// (shadow memory, expected-response queue with arrival times, turn flag).

module tb_knn_local_sp_arbiter;

  localparam int DW     = 256;
  localparam int AW     = 11;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] mem_address0;
  logic          mem_ce0;
  logic          mem_we0;
  logic [DW-1:0] mem_d0;
  logic [DW-1:0] mem_q0;
`ifdef KNN_SP_ARB_STATS_EN
  logic [31:0]   stat_conflict;
  logic [31:0]   stat_rd_nocredit;
`endif

  knn_local_sp_arbiter #(
    .DataWidth(DW), .AddressWidth(AW), .RD_LAT(RD_LAT), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
    .mem_d0(mem_d0), .mem_q0(mem_q0)
`ifdef KNN_SP_ARB_STATS_EN
    , .stat_conflict(stat_conflict), .stat_rd_nocredit(stat_rd_nocredit)
`endif
  );

  always #5 clk = ~clk;

  int cycleNum = 0;
  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Pre-load content for never-written locations, shared by memory and model.
  function automatic logic [DW-1:0] initWord(input int i);
    return {8{32'(i) * 32'h9E37_79B1}};
  endfunction

  function automatic logic [DW-1:0] randWord();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Single-port URAM behavioural model with RD_LAT cycles of read latency.
  logic [DW-1:0] memArr  [2**AW];
  bit            memWritten [2**AW];
  logic [DW-1:0] qPipe   [RD_LAT];

  always @(posedge clk) begin
    if (mem_ce0 && !mem_we0)
      qPipe[0] <= memWritten[mem_address0] ? memArr[mem_address0] : initWord(int'(mem_address0));
    else
      qPipe[0] <= '0;
    for (int i = 1; i < RD_LAT; i++) qPipe[i] <= qPipe[i-1];
    if (mem_ce0 && mem_we0) begin
      memArr[mem_address0]     = mem_d0;
      memWritten[mem_address0] = 1'b1;
    end
  end
  assign mem_q0 = qPipe[RD_LAT-1];

  // Reference model state.
  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } rsp_t;

  logic [DW-1:0] shadow [2**AW];
  rsp_t          expQ[$];
  bit            writeTurn;
  int            conflictCnt;
  int            noCreditCnt;

  int  checkCount = 0;
  int  passCount  = 0;
  int  failCount  = 0;
  bit  obsW, obsR;

  bit            wPend, rPend;
  logic [AW-1:0] wA, rA;
  logic [DW-1:0] wD;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare, then advance the model.
  task automatic applyStimulus(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input bit rv, input logic [AW-1:0] ra, input bit rr,
                               input bit rst, output bit gW, output bit gR);
    bit eW, eR, expValid;
    @(negedge clk);
    reset     = rst;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    rd_valid  = rv;
    rd_addr   = ra;
    rsp_ready = rr;
    #1;
    obsW = wr_ready;
    obsR = rd_ready;
    gW = 1'b0;
    gR = 1'b0;
    if (rst) begin
      checkOutput("rst_wr_ready", DW'(wr_ready), DW'(1'b0));
      checkOutput("rst_rd_ready", DW'(rd_ready), DW'(1'b0));
      checkOutput("rst_mem_ce0",  DW'(mem_ce0),  DW'(1'b0));
      checkOutput("rst_mem_we0",  DW'(mem_we0),  DW'(1'b0));
      expQ.delete();
      writeTurn   = 1'b0;
      conflictCnt = 0;
      noCreditCnt = 0;
    end else begin
      eW = wv;
      eR = rv && (expQ.size() < DEPTH);
`ifdef KNN_SP_ARB_STATS_EN
      checkOutput("stat_conflict",    DW'(stat_conflict),    DW'(conflictCnt));
      checkOutput("stat_rd_nocredit", DW'(stat_rd_nocredit), DW'(noCreditCnt));
`endif
      if (rv && expQ.size() == DEPTH) noCreditCnt++;
      if (eW && eR) begin
        conflictCnt++;
        gW = writeTurn;
        gR = !writeTurn;
        writeTurn = gR;
      end else begin
        gW = eW;
        gR = eR;
      end
      expValid = (expQ.size() > 0) && (expQ[0].avail <= cycleNum);
      checkOutput("wr_ready", DW'(wr_ready), DW'(gW));
      checkOutput("rd_ready", DW'(rd_ready), DW'(gR));
      checkOutput("mem_ce0",  DW'(mem_ce0),  DW'(gW || gR));
      checkOutput("mem_we0",  DW'(mem_we0),  DW'(gW));
      if (gW || gR) checkOutput("mem_address0", DW'(mem_address0), DW'(gW ? wa : ra));
      if (gW) checkOutput("mem_d0", mem_d0, wd);
      checkOutput("rsp_valid", DW'(rsp_valid), DW'(expValid));
      if (expValid) checkOutput("rsp_data", rsp_data, expQ[0].data);
      if (expValid && rr) void'(expQ.pop_front());
      if (gW) shadow[wa] = wd;
      if (gR) expQ.push_back('{shadow[ra], cycleNum + RD_LAT + 1});
    end
  endtask

  // Drive the currently pending requests; a granted request is retired.
  task automatic step(input bit rr, input bit rst);
    bit gW, gR;
    applyStimulus(wPend, wA, wD, rPend, rA, rr, rst, gW, gR);
    if (gW) wPend = 1'b0;
    if (gR) rPend = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expQ.size() > 0; i++) step(1'b1, 1'b0);
  endtask

  int grantCycle, firstSeen, cntW, cntR, reqIssued;
  logic [DW-1:0] patA5;

  initial begin
    for (int i = 0; i < 2**AW; i++) shadow[i] = initWord(i);
    wPend = 0; rPend = 0; wA = '0; rA = '0; wD = '0;
    patA5 = {32{8'hA5}};

    // Reset state.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);

    // Write then read 0x005: response appears RD_LAT+1 cycles after the grant.
    wPend = 1; wA = 11'h005; wD = patA5;
    step(1'b1, 1'b0);
    rPend = 1; rA = 11'h005;
    step(1'b1, 1'b0);
    grantCycle = cycleNum;
    firstSeen  = -1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      if (rsp_valid && firstSeen < 0) firstSeen = cycleNum;
    end
    checkOutput("rsp_latency", DW'(firstSeen - grantCycle), DW'(RD_LAT + 1));

    // Both requesters busy from reset: R,W alternation, first grant to read.
    step(1'b0, 1'b1);
    cntW = 0; cntR = 0;
    for (int i = 0; i < 8; i++) begin
      if (!wPend) begin wPend = 1; wA = AW'(11'h100 + i); wD = randWord(); end
      if (!rPend) begin rPend = 1; rA = AW'(11'h100 + i); end
      step(1'b1, 1'b0);
      if (i == 0) checkOutput("first_contest_read", DW'(obsR), DW'(1'b1));
      cntW += int'(obsW);
      cntR += int'(obsR);
    end
    checkOutput("contest_writes", DW'(cntW), DW'(4));
    checkOutput("contest_reads",  DW'(cntR), DW'(4));
    step(1'b1, 1'b0);
`ifdef KNN_SP_ARB_STATS_EN
    checkOutput("stat_conflict_8", DW'(stat_conflict), DW'(8));
`endif
    for (int i = 0; i < 6 && (wPend || rPend); i++) step(1'b1, 1'b0);
    drain();

    // 16 back-to-back reads at full throughput.
    cntR = 0;
    for (int i = 0; i < 16; i++) begin
      rPend = 1; rA = AW'(i);
      step(1'b1, 1'b0);
      cntR += int'(obsR);
    end
    rPend = 0;
    checkOutput("b2b_reads", DW'(cntR), DW'(16));
    drain();

    // Credit limit: with rsp_ready low only DEPTH of 6 reads are accepted.
    cntR = 0; reqIssued = 1; rPend = 1; rA = 11'h040;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      cntR += int'(obsR);
      if (!rPend && reqIssued < 6) begin rPend = 1; rA = AW'(11'h040 + reqIssued); reqIssued++; end
    end
    checkOutput("credit_limited_reads", DW'(cntR), DW'(DEPTH));
    for (int i = 0; i < 30 && (rPend || reqIssued < 6); i++) begin
      step(1'b1, 1'b0);
      cntR += int'(obsR);
      if (!rPend && reqIssued < 6) begin rPend = 1; rA = AW'(11'h040 + reqIssued); reqIssued++; end
    end
    checkOutput("credit_total_reads", DW'(cntR), DW'(6));
    drain();

    // Reset with two reads in flight: they vanish, memory keeps its data.
    rPend = 1; rA = 11'h005;
    step(1'b1, 1'b0);
    rPend = 1; rA = 11'h006;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    rPend = 1; rA = 11'h005;
    step(1'b1, 1'b0);
    drain();

    // Top-of-range address: write 0x7FF then read it the following cycle.
    wPend = 1; wA = 11'h7FF; wD = randWord();
    step(1'b1, 1'b0);
    rPend = 1; rA = 11'h7FF;
    step(1'b1, 1'b0);
    drain();

    // Random traffic with requesters holding requests until accepted.
    for (int i = 0; i < 500; i++) begin
      if (!wPend && $urandom_range(0, 99) < 45) begin
        wPend = 1;
        wA = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 2047)) : AW'($urandom_range(0, 15));
        wD = randWord();
      end
      if (!rPend && $urandom_range(0, 99) < 55) begin
        rPend = 1;
        rA = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 2047)) : AW'($urandom_range(0, 15));
      end
      step($urandom_range(0, 99) < 65, $urandom_range(0, 199) == 0);
    end
    wPend = 0; rPend = 0;
    drain();
    step(1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
